// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// imem_loader_pkg : shared FSM encoding and sizing constants for the loader
// Revision: 1.0
// ============================================================================
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CSUM  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// word_assembler : little-endian byte-to-word shift register with byte counter
// Revision: 1.0
// ============================================================================
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_clr,
  input  logic                         i_accept,
  input  logic [7:0]                   i_byte,
  output logic [8*BYTES_PER_WORD-1:0]  o_word,
  output logic [8*BYTES_PER_WORD-1:0]  o_next_word,
  output logic                         o_last
);

  logic [8*BYTES_PER_WORD-1:0] r_word;
  logic [1:0]                  r_cnt;

  // Shifting in from the top leaves the first byte in bits [7:0] after four pushes.
  assign o_next_word = {i_byte, r_word[8*BYTES_PER_WORD-1:8]};
  assign o_word      = r_word;
  assign o_last      = (r_cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_accept) begin
      r_word <= o_next_word;
      r_cnt  <= r_cnt + 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// imem_loader : streams bytes into instruction memory, verifies XOR checksum
// Revision: 1.0
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] load_len,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             core_hold,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t            r_state;
  state_t            w_next;
  logic [LEN_W-1:0]  r_len;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_csum;

  logic              w_accept;
  logic              w_begin;
  logic              w_too_big;
  logic              w_last_word;
  logic [31:0]       w_asm_word;
  logic [31:0]       w_asm_next;
  logic              w_asm_last;

  word_assembler u_asm (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_begin),
    .i_accept    (w_accept),
    .i_byte      (in_data),
    .o_word      (w_asm_word),
    .o_next_word (w_asm_next),
    .o_last      (w_asm_last)
  );

  assign in_ready    = (r_state == S_RECV) || (r_state == S_CSUM);
  assign w_accept    = in_valid && in_ready;
  assign w_too_big   = (32'(load_len) > (32'd1 << ADDR_W));
  assign w_last_word = (LEN_W'(r_idx) == (r_len - LEN_W'(1)));

  assign imem_we    = (r_state == S_WRITE);
  assign imem_addr  = 32'(r_addr);
  assign imem_wdata = r_wdata;
  assign busy       = (r_state == S_RECV) || (r_state == S_WRITE) || (r_state == S_CSUM);
  assign done       = (r_state == S_DONE);
  assign err        = (r_state == S_ERR);
  assign core_hold  = (r_state != S_DONE);

  always_comb begin
    w_next  = r_state;
    w_begin = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          if (load_len == '0) begin
            w_next = S_DONE;
          end else if (w_too_big) begin
            w_next = S_ERR;
          end else begin
            w_next  = S_RECV;
            w_begin = 1'b1;
          end
        end
      end
      S_RECV: begin
        if (w_accept && w_asm_last) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_next = w_last_word ? S_CSUM : S_RECV;
      end
      S_CSUM: begin
        if (w_accept && w_asm_last) w_next = (w_asm_next == r_csum) ? S_DONE : S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_idx   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_csum  <= '0;
    end else begin
      r_state <= w_next;
      if (w_begin) begin
        r_len  <= load_len;
        r_idx  <= '0;
        r_csum <= '0;
      end
      // Address and data are captured on entry to WRITE and held afterwards.
      if ((r_state == S_RECV) && w_accept && w_asm_last) begin
        r_addr  <= r_idx;
        r_wdata <= w_asm_next;
      end
      if (r_state == S_WRITE) begin
        r_csum <= r_csum ^ w_asm_word;
        r_idx  <= r_idx + ADDR_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// tb_imem_loader : directed scoreboard bench for imem_loader
// Revision: 1.0
// ============================================================================
module tb_imem_loader;

  localparam int ADDR_W = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] load_len;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        err;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          we_count = 0;
  int          cyc      = 0;
  logic [63:0] sb[$];
  logic [63:0] sb_exp;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load_len   (load_len),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      we_count++;
      sb_exp = (sb.size() > 0) ? sb.pop_front() : {64{1'b1}};
      check("imem_write", {imem_addr, imem_wdata}, sb_exp);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic [15:0] len);
    load_len = len;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int n;
    bit acc;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    n        = 0;
    acc      = 1'b0;
    do begin
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) check("byte_accept", {63'd0, acc}, 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], max_gap);
  endtask

  initial begin
    logic [31:0] w[3];
    logic [31:0] cs;
    int          t0;

    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; load_len = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  {63'd0, in_ready},  64'd0);
    check("rst_imem_we",   {63'd0, imem_we},   64'd0);
    check("rst_imem_addr", {32'd0, imem_addr}, 64'd0);
    check("rst_wdata",     {32'd0, imem_wdata},64'd0);
    check("rst_flags",     {60'd0, busy, done, err, core_hold}, 64'b0001);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_rst", {59'd0, in_ready, busy, done, err, core_hold}, 64'b00001);

    // Two-word load with a correct checksum.
    we_count = 0;
    sb.push_back({32'd0, 32'h0000_0013});
    sb.push_back({32'd1, 32'h0010_0093});
    pulse_start(16'd2);
    t0 = cyc;
    check("t1_busy", {63'd0, busy}, 64'd1);
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 0);
    send_word(32'h0010_0080, 0);
    in_valid = 1'b0;
    check("t1_latency", 64'(cyc - t0), 64'd14);
    check("t1_flags", {60'd0, busy, done, err, core_hold}, 64'b0100);
    check("t1_we_count", 64'(we_count), 64'd2);
    check("t1_sb_empty", 64'(sb.size()), 64'd0);

    // Same stream, bad checksum.
    we_count = 0;
    sb.push_back({32'd0, 32'h0000_0013});
    sb.push_back({32'd1, 32'h0010_0093});
    pulse_start(16'd2);
    check("t2_done_clears", {62'd0, busy, done}, 64'b10);
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 0);
    send_word(32'h0000_0000, 0);
    in_valid = 1'b0;
    check("t2_flags", {60'd0, busy, done, err, core_hold}, 64'b0011);
    check("t2_we_count", 64'(we_count), 64'd2);

    // Length boundaries.
    we_count = 0;
    pulse_start(16'd0);
    check("t3_len0", {60'd0, busy, done, err, core_hold}, 64'b0100);
    pulse_start(16'd1025);
    check("t3_len1025", {60'd0, busy, done, err, core_hold}, 64'b0011);
    pulse_start(16'd1024);
    check("t3_len1024_busy", {61'd0, busy, done, err}, 64'b100);
    check("t3_we_count", 64'(we_count), 64'd0);
    rst = 1'b0;
    #1;
    check("t3_rst_abort", {62'd0, busy, core_hold}, 64'b01);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Three words with random valid gaps.
    we_count = 0;
    cs = '0;
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom;
      cs   = cs ^ w[i];
      sb.push_back({32'(i), w[i]});
    end
    pulse_start(16'd3);
    for (int i = 0; i < 3; i++) send_word(w[i], 3);
    send_word(cs, 3);
    in_valid = 1'b0;
    check("t4_flags", {60'd0, busy, done, err, core_hold}, 64'b0100);
    check("t4_we_count", 64'(we_count), 64'd3);

    // Start ignored mid-load, then reset after six bytes.
    we_count = 0;
    w[0] = 32'h1234_5678;
    w[1] = 32'h9abc_def0;
    sb.push_back({32'd0, w[0]});
    pulse_start(16'd2);
    send_byte(w[0][7:0], 0);
    send_byte(w[0][15:8], 0);
    in_valid = 1'b0;
    load_len = 16'd0;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    check("t5_start_ignored", {61'd0, busy, done, err}, 64'b100);
    send_byte(w[0][23:16], 0);
    send_byte(w[0][31:24], 0);
    send_byte(w[1][7:0], 0);
    send_byte(w[1][15:8], 0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("t5_rst_now", {61'd0, in_ready, busy, core_hold}, 64'b001);
    check("t5_we_count", 64'(we_count), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    sb.push_back({32'd0, 32'hdead_beef});
    pulse_start(16'd1);
    send_word(32'hdead_beef, 0);
    send_word(32'hdead_beef, 0);
    in_valid = 1'b0;
    check("t5_fresh_load", {60'd0, busy, done, err, core_hold}, 64'b0100);
    check("t5_sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning the instruction-memory word-address width (depth 2^ADDR_W words).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, a one-cycle request to begin a load.
REQ-005 The block SHALL have port load_len, input, 16, the number of 32-bit words to load, sampled on start.
REQ-006 The block SHALL have port in_valid, input, 1, byte-stream valid.
REQ-007 The block SHALL have port in_data, input, 8, byte-stream data.
REQ-008 The block SHALL have port in_ready, output, 1, byte-stream ready.
REQ-009 The block SHALL have port imem_we, output, 1, instruction-memory write strobe.
REQ-010 The block SHALL have port imem_addr, output, 32, instruction-memory word address, zero-extended from ADDR_W bits.
REQ-011 The block SHALL have port imem_wdata, output, 32, instruction word to write.
REQ-012 The block SHALL have port core_hold, output, 1; while it is 1 the processor pipeline is held in reset.
REQ-013 The block SHALL have port busy, output, 1, meaning a load is in progress.
REQ-014 The block SHALL have port done, output, 1, meaning the last load succeeded.
REQ-015 The block SHALL have port err, output, 1, meaning the last load failed.

Function
REQ-016 The FSM SHALL have states IDLE, RECV, WRITE, CSUM, DONE and ERR.
REQ-017 A byte SHALL transfer only on a cycle where in_valid and in_ready are both 1; in_ready SHALL be 1 only in RECV and CSUM.
REQ-018 On start in IDLE, DONE or ERR: load_len=0 -> DONE; load_len>2^ADDR_W -> ERR; otherwise the block latches the length, clears the word index, byte count and checksum, and enters RECV.
REQ-019 start in RECV, WRITE or CSUM SHALL be ignored.
REQ-020 RECV SHALL assemble bytes little-endian: byte 0 goes to bits [7:0] and byte 3 to bits [31:24].
REQ-021 The 4th accepted byte SHALL move the FSM to WRITE on the next edge.
REQ-022 WRITE SHALL last exactly 1 cycle, with imem_we=1, imem_addr=word index and imem_wdata=assembled word.
REQ-023 In WRITE the running checksum SHALL be XORed with the assembled word.
REQ-024 After WRITE the word index SHALL increment; if the written index equals len-1 the FSM goes to CSUM, otherwise to RECV.
REQ-025 CSUM SHALL accept 4 bytes (little-endian) and compare them with the running XOR: equal -> DONE, unequal -> ERR.
REQ-026 imem_we SHALL be 0 outside WRITE; imem_addr and imem_wdata hold their last values.
REQ-027 busy SHALL be 1 in RECV, WRITE and CSUM.
REQ-028 done SHALL be 1 only in DONE and err only in ERR; both clear when a new load begins.
REQ-029 core_hold SHALL be 0 only in DONE.
REQ-030 Stream latency SHALL be at most 5 cycles per word with in_valid held at 1: 4 byte cycles plus 1 write cycle.
REQ-031 When the word index wraps at 2^ADDR_W, the load SHALL already have ended through the length check in REQ-018.
REQ-032 Stalls on in_valid SHALL be unbounded, with no timeout.

Reset
REQ-033 While rst=0, the block SHALL be in IDLE with in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, core_hold=1, and all counters and the checksum at 0.
REQ-034 Reset asserted mid-load SHALL abort the load immediately; words already written stay in memory.
REQ-035 After rst deasserts, the block SHALL do nothing until start.

Structure
REQ-036 The FSM state encoding and the constants BYTES_PER_WORD=4 and LEN_W=16 SHALL live in the shared processor package.
REQ-037 The byte-to-word assembler (shift register plus 2-bit byte counter, shared by RECV and CSUM) SHALL be the one sub-module, named word_assembler.

Verification
REQ-038 The bench SHALL cover: load_len=2, bytes 13 00 00 00 93 00 10 00, checksum bytes 80 00 10 00 -> writes addr0=00000013 and addr1=00100093, done=1, core_hold=0.
REQ-039 The bench SHALL cover: same stream with checksum 00 00 00 00 -> both writes occur, err=1, core_hold=1.
REQ-040 The bench SHALL cover: load_len=0 -> DONE on the next edge with no imem_we pulse; load_len=1025 (ADDR_W=10) -> ERR with no writes.
REQ-041 The bench SHALL cover: random in_valid gaps on a 3-word load -> identical writes and exactly 3 imem_we pulses.
REQ-042 The bench SHALL cover: start pulsed during RECV -> ignored; rst=0 after 6 bytes -> IDLE and core_hold=1 at once, then a fresh load succeeds.
